// File: rtl/jal_link_pkg.sv
// Shared decode constants and types for the jump/link path of the core.
package jal_link_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;

    // Opcode / funct encodings
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] FN_JALR    = 6'b001001;
    localparam logic [5:0] FN_JR      = 6'b001000;

    // Architectural link register for JAL
    localparam logic [REG_W-1:0] LINK_REG = 5'd31;

    // Instruction field slice positions
    localparam int unsigned OP_MSB  = 31;
    localparam int unsigned OP_LSB  = 26;
    localparam int unsigned RS_MSB  = 25;
    localparam int unsigned RS_LSB  = 21;
    localparam int unsigned RD_MSB  = 15;
    localparam int unsigned RD_LSB  = 11;
    localparam int unsigned FN_MSB  = 5;
    localparam int unsigned FN_LSB  = 0;
    localparam int unsigned TGT_MSB = 25;
    localparam int unsigned TGT_LSB = 0;

    // One queued link write: destination register plus return address
    typedef struct packed {
        logic [REG_W-1:0] addr;
        logic [XLEN-1:0]  data;
    } link_entry_t;

    typedef enum logic [1:0] {
        JmpNone,
        JmpJal,
        JmpJalr
    } jump_kind_e;

    function automatic jump_kind_e decode_jump(input logic [XLEN-1:0] instr);
        jump_kind_e kind;
        kind = JmpNone;
        if (instr[OP_MSB:OP_LSB] == OP_JAL) begin
            kind = JmpJal;
        end else if (instr[OP_MSB:OP_LSB] == OP_SPECIAL &&
                     instr[FN_MSB:FN_LSB] == FN_JALR) begin
            kind = JmpJalr;
        end
        return kind;
    endfunction

endpackage

// File: rtl/link_fifo.sv
// Two-entry FIFO of pending link writes. The head output keeps the last
// popped entry once the queue drains, so the write port sees stable values.
module link_fifo
    import jal_link_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push_i,
    input  logic        pop_i,
    input  link_entry_t din_i,
    output link_entry_t dout_o,
    output logic        full_o,
    output logic        empty_o
);

    link_entry_t mem_q [2];
    link_entry_t last_q;
    logic        wr_ptr_q;
    logic        rd_ptr_q;
    logic [1:0]  count_q;
    logic        do_push;
    logic        do_pop;

    // Status decode and guarded handshakes
    always_comb begin
        full_o  = (count_q == 2'd2);
        empty_o = (count_q == 2'd0);
        do_push = push_i & ~full_o;
        do_pop  = pop_i & ~empty_o;
        dout_o  = empty_o ? last_q : mem_q[rd_ptr_q];
    end

    // Storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            last_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                last_q   <= mem_q[rd_ptr_q];
                rd_ptr_q <= ~rd_ptr_q;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/jal_link.sv
// Link-and-jump unit: redirects the PC on JAL/JALR and queues the return
// address for write-back through a request/grant register-file port.
module jal_link
    import jal_link_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid_i,
    input  logic [XLEN-1:0]  instru_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [XLEN-1:0]  data_a_i,
    input  logic             wr_gnt_i,
    output logic [XLEN-1:0]  pc_next_o,
    output logic             pc_load_o,
    output logic             wr_req_o,
    output logic [REG_W-1:0] wr_addr_o,
    output logic [XLEN-1:0]  wr_data_o,
    output logic             stall_o
);

    jump_kind_e       kind;
    logic             accept;
    logic [XLEN-1:0]  pc4;
    logic [XLEN-1:0]  target;
    logic [REG_W-1:0] link_reg;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    link_entry_t      push_entry;
    link_entry_t      head;
    logic [XLEN-1:0]  pc_next_q;
    logic             pc_load_q;

    // Decode, target selection and queue handshakes
    always_comb begin
        kind     = decode_jump(instru_i);
        pc4      = pc_i + 32'd4;
        // Stall blocks accept even if the queue pops this cycle
        accept   = instr_valid_i & (kind != JmpNone) & ~fifo_full;
        target   = {pc4[31:28], instru_i[TGT_MSB:TGT_LSB], 2'b00};
        link_reg = LINK_REG;
        if (kind == JmpJalr) begin
            target   = data_a_i;
            link_reg = instru_i[RD_MSB:RD_LSB];
        end
        push            = accept & (link_reg != '0);
        push_entry.addr = link_reg;
        push_entry.data = pc4;
        pop             = ~fifo_empty & wr_gnt_i;
    end

    // Registered PC redirect: one-cycle load pulse, target held otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_next_q <= '0;
            pc_load_q <= 1'b0;
        end else begin
            pc_load_q <= accept;
            if (accept) begin
                pc_next_q <= target;
            end
        end
    end

    link_fifo u_link_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (push_entry),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Output mapping
    always_comb begin
        pc_next_o = pc_next_q;
        pc_load_o = pc_load_q;
        wr_req_o  = ~fifo_empty;
        wr_addr_o = head.addr;
        wr_data_o = head.data;
        stall_o   = fifo_full;
    end

endmodule

// File: tb/tb_jal_link.sv
// Directed bench for jal_link: a cycle-by-cycle vector table plus
// hand-written stall/drain and asynchronous-reset sequences.
module tb_jal_link;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instru;
    logic [31:0] pc;
    logic [31:0] data_a;
    logic        wr_gnt;
    logic [31:0] pc_next;
    logic        pc_load;
    logic        wr_req;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        stall;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    jal_link dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_valid_i (instr_valid),
        .instru_i      (instru),
        .pc_i          (pc),
        .data_a_i      (data_a),
        .wr_gnt_i      (wr_gnt),
        .pc_next_o     (pc_next),
        .pc_load_o     (pc_load),
        .wr_req_o      (wr_req),
        .wr_addr_o     (wr_addr),
        .wr_data_o     (wr_data),
        .stall_o       (stall)
    );

    typedef struct {
        logic        valid;
        logic [31:0] instru;
        logic [31:0] pc;
        logic [31:0] data_a;
        logic        gnt;
        logic        e_load;
        logic [31:0] e_next;
        logic        e_req;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic        e_stall;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic v, logic [31:0] ins, logic [31:0] p, logic [31:0] a,
                                logic g, logic el, logic [31:0] en, logic er,
                                logic [4:0] ea, logic [31:0] ed, logic es);
        vec_t r;
        r.valid = v; r.instru = ins; r.pc = p; r.data_a = a; r.gnt = g;
        r.e_load = el; r.e_next = en; r.e_req = er; r.e_addr = ea; r.e_data = ed;
        r.e_stall = es;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic el, input logic [31:0] en,
                           input logic er, input logic [4:0] ea, input logic [31:0] ed,
                           input logic es);
        chk({tag, ".pc_load"}, {31'd0, pc_load}, {31'd0, el});
        chk({tag, ".pc_next"}, pc_next, en);
        chk({tag, ".wr_req"},  {31'd0, wr_req},  {31'd0, er});
        chk({tag, ".wr_addr"}, {27'd0, wr_addr}, {27'd0, ea});
        chk({tag, ".wr_data"}, wr_data, ed);
        chk({tag, ".stall"},   {31'd0, stall},   {31'd0, es});
    endtask

    // Drive one cycle of inputs from a negedge, sample at the next negedge
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] p,
                        input logic [31:0] a, input logic g);
        instr_valid = v; instru = ins; pc = p; data_a = a; wr_gnt = g;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [31:0] NOP = 32'h0000_0000;

    initial begin
        rst_n = 1'b0;
        instr_valid = 1'b0; instru = NOP; pc = '0; data_a = '0; wr_gnt = 1'b0;

        // JAL=0x0C000010 target field 0x10 -> 0x40; JALR rs=4 rd=5 = 0x00802809
        // JALR rs=4 rd=0 = 0x00800009; JR rs=4 = 0x00800008; JALR rs=rd=7 = 0x00E03809
        tbl.push_back(mk(1, 32'h0C00_0010, 32'h0040_0000, 32'h0, 1,
                         1, 32'h0000_0040, 1, 5'd31, 32'h0040_0004, 0));
        tbl.push_back(mk(1, 32'h0080_2809, 32'h0040_0100, 32'h0040_1230, 1,
                         1, 32'h0040_1230, 1, 5'd5, 32'h0040_0104, 0));
        tbl.push_back(mk(1, 32'h0080_0009, 32'h0040_0200, 32'h1234_5678, 1,
                         1, 32'h1234_5678, 0, 5'd5, 32'h0040_0104, 0));
        tbl.push_back(mk(0, 32'h0C00_0010, 32'h0040_0300, 32'h0, 1,
                         0, 32'h1234_5678, 0, 5'd5, 32'h0040_0104, 0));
        tbl.push_back(mk(1, 32'h0080_0008, 32'h0040_0400, 32'hAAAA_0000, 0,
                         0, 32'h1234_5678, 0, 5'd5, 32'h0040_0104, 0));
        tbl.push_back(mk(0, NOP, 32'h0, 32'h0, 1,
                         0, 32'h1234_5678, 0, 5'd5, 32'h0040_0104, 0));
        // pc wrap: pc4 = 0, upper nibble of target comes from pc4
        tbl.push_back(mk(1, 32'h0FFF_FFFF, 32'hFFFF_FFFC, 32'h0, 0,
                         1, 32'h0FFF_FFFC, 1, 5'd31, 32'h0000_0000, 0));
        tbl.push_back(mk(0, NOP, 32'h0, 32'h0, 0,
                         0, 32'h0FFF_FFFC, 1, 5'd31, 32'h0000_0000, 0));
        tbl.push_back(mk(0, NOP, 32'h0, 32'h0, 1,
                         0, 32'h0FFF_FFFC, 0, 5'd31, 32'h0000_0000, 0));
        // rd == rs: target is the pre-write register value
        tbl.push_back(mk(1, 32'h00E0_3809, 32'h0040_0300, 32'hDEAD_BEE0, 0,
                         1, 32'hDEAD_BEE0, 1, 5'd7, 32'h0040_0304, 0));
        tbl.push_back(mk(0, NOP, 32'h0, 32'h0, 1,
                         0, 32'hDEAD_BEE0, 0, 5'd7, 32'h0040_0304, 0));

        @(negedge clk);
        chk_all("reset", 0, 32'h0, 0, 5'd0, 32'h0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].valid, tbl[i].instru, tbl[i].pc, tbl[i].data_a, tbl[i].gnt);
            chk_all($sformatf("vec%0d", i), tbl[i].e_load, tbl[i].e_next, tbl[i].e_req,
                    tbl[i].e_addr, tbl[i].e_data, tbl[i].e_stall);
        end

        // Three JALs with the write port blocked, then drain in order
        step(1, 32'h0C00_0100, 32'h0000_1000, 32'h0, 0);
        chk_all("fill1", 1, 32'h0000_0400, 1, 5'd31, 32'h0000_1004, 0);
        step(1, 32'h0C00_0200, 32'h0000_2000, 32'h0, 0);
        chk_all("fill2", 1, 32'h0000_0800, 1, 5'd31, 32'h0000_1004, 1);
        step(1, 32'h0C00_0300, 32'h0000_3000, 32'h0, 0);
        chk_all("blocked", 0, 32'h0000_0800, 1, 5'd31, 32'h0000_1004, 1);
        step(1, 32'h0C00_0300, 32'h0000_3000, 32'h0, 1);
        chk_all("drain1", 0, 32'h0000_0800, 1, 5'd31, 32'h0000_2004, 0);
        step(1, 32'h0C00_0300, 32'h0000_3000, 32'h0, 1);
        chk_all("repres", 1, 32'h0000_0C00, 1, 5'd31, 32'h0000_3004, 0);
        step(0, NOP, 32'h0, 32'h0, 1);
        chk_all("drain3", 0, 32'h0000_0C00, 0, 5'd31, 32'h0000_3004, 0);

        // Fill the queue, then reset asynchronously in mid-cycle
        step(1, 32'h0C00_0010, 32'h0000_0100, 32'h0, 0);
        step(1, 32'h0C00_0020, 32'h0000_0200, 32'h0, 0);
        chk_all("prerst", 1, 32'h0000_0080, 1, 5'd31, 32'h0000_0104, 1);
        instr_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_all("asyncrst", 0, 32'h0, 0, 5'd0, 32'h0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, NOP, 32'h0, 32'h0, 0);
        chk_all("postrst1", 0, 32'h0, 0, 5'd0, 32'h0, 0);
        step(0, NOP, 32'h0, 32'h0, 1);
        chk_all("postrst2", 0, 32'h0, 0, 5'd0, 32'h0, 0);
        step(1, 32'h0C00_0010, 32'h0040_0000, 32'h0, 0);
        chk_all("postrst3", 1, 32'h0000_0040, 1, 5'd31, 32'h0040_0004, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
